multi_counter: RTL and testbench
================================

# multi_counter

Parametrised multi-channel interval timer that generalises the single-channel interrupt counter. It provides NUM_CH independent WIDTH-bit counters behind a shared prescaler. Each channel has a one-shot or periodic mode, a sticky pending flag with explicit acknowledge, and a combined interrupt line. It sits on the peripheral side of the CPU and drives the interrupt input in place of the single counter.

## Interface
- NUM_CH, 4, number of timer channels (1..16)
- WIDTH, 32, counter and compare width in bits
- PRESCALE, 1, clock cycles per count tick (>=1; 1 = tick every cycle)
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- ch_sel  in  CH_W  channel addressed by set/stop and readback
- set  in  1  pulse: load val1/mode into ch_sel, clear its count, enable it
- stop  in  1  pulse: disable channel ch_sel (count holds)
- mode  in  1  sampled with set: 1 = periodic, 0 = one-shot
- val1  in  WIDTH  compare value sampled with set
- ack  in  NUM_CH  per-channel pending clear, level-sampled each edge
- pending  out  NUM_CH  sticky per-channel match flags
- c_int  out  1  OR of pending
- rd_count  out  WIDTH  current count of channel ch_sel (combinational mux)

## Operation
- Per-channel state: cnt[WIDTH], cmp[WIDTH], en, per (mode), pend.
- Reset values:
  - cnt = 0, cmp = all ones, en = 0, per = 0, pend = 0.
  - Prescaler = 0.
  - Outputs pending = 0, c_int = 0, rd_count = 0.
- Prescaler:
  - Free-running 0..PRESCALE-1 from reset.
  - tick = (pre == PRESCALE-1). With PRESCALE=1, tick is constant 1.
  - set does not restart the prescaler.
- Per channel, evaluated in priority order each edge:
  1. set addressed to this channel: cnt <= 0, cmp <= val1, per <= mode, en <= 1.
  2. stop addressed to this channel: en <= 0; cnt holds.
  3. en && tick && cnt == cmp:
     - cnt <= 0, pend <= 1.
     - If per == 0, en <= 0 (one-shot done).
  4. en && tick: cnt <= cnt + 1, wrapping modulo 2^WIDTH (only reachable if cmp changed; not expected).
  5. Otherwise hold.
- Pending:
  - pend <= 0 when ack[i] = 1.
  - A match in the same cycle as ack wins: pend stays 1.
  - set does not clear pend; software acks separately.
- set and stop in the same cycle: set wins.
- Disabled channels never set pend. Their cnt is frozen and visible on rd_count.
- Channels do not interact, except through the shared prescaler and c_int.
- ch_sel >= NUM_CH: set and stop are ignored, rd_count = 0.

## Timing
- Period is cmp+1 ticks. The count sequence is 0,1,...,cmp,0,...
- PRESCALE=1, set at edge k:
  - cnt = 0 after edge k.
  - cnt = cmp after edge k+cmp.
  - pend = 1 after edge k+cmp+1.
  - Periodic mode: pend is re-asserted every cmp+1 cycles thereafter.
- cmp = 0 periodic: match on every tick.
- PRESCALE=P: the first match occurs at the (cmp+1)-th tick after set. Latency from set is (cmp+1)·P cycles minus the prescaler phase, so it ranges from cmp·P+1 to (cmp+1)·P cycles.
- c_int and pending are register outputs (plus OR). No combinational path from inputs to pending or c_int.
- rd_count is combinational from ch_sel and registers.
- Async reset asserted mid-count: all outputs 0 immediately, without waiting for an edge. Release is synchronous to the next edge; the first tick occurs PRESCALE edges after release.

## Test plan
- Reset then idle 100 cycles, NUM_CH=4, PRESCALE=1 -> pending = 0, c_int = 0, rd_count = 0 on all channels.
- Set ch0, val1=5, mode=1 at edge 10:
  - pending[0] rises after edges 16, 22, 28.
  - ack[0] pulsed at edge 17 -> pending[0] falls after edge 17, rises again after edge 22.
  - c_int tracks pending[0].
- Set ch2, val1=3, mode=0 -> pending[2] = 1 after 4 cycles, channel then disabled; rd_count stays 0 for 20 cycles, no further match.
- Set ch1, val1=2, mode=1, with ack[1] held high continuously -> pending[1] = 1 after every match edge, clear one cycle later (match beats ack, ack clears next).
- Set ch3, val1=10 mode=1; stop ch3 at cnt=4 -> rd_count frozen at 4 and no pending. Then issue set+stop together on ch3 with val1=1 -> channel runs (set wins) and pending[3] rises after 2 cycles.
- PRESCALE=4 build: set ch0, val1=2 -> pending[0] rises between 9 and 12 cycles after set. Assert reset low mid-count -> pending, c_int, rd_count = 0 without a clock edge; after release, no pending until a new set.

Source files
------------

// File: rtl/multi_counter_if.sv
// multi_counter_if -- CPU-side bus of the multi-channel interval timer.
//
// Signal semantics (no valid/ready handshake; every control is a plain
// single-cycle command sampled on the rising clock edge):
//   ch_sel   channel addressed by set/stop, and the channel shown on rd_count
//   set      pulse: load val1/mode into ch_sel, clear its count, enable it
//   stop     pulse: disable ch_sel, its count holds
//   mode     sampled with set: 1 = periodic, 0 = one-shot
//   val1     compare value sampled with set
//   ack      per-channel pending clear, level-sampled every edge
//   pending  sticky per-channel match flags (registered)
//   c_int    OR of pending
//   rd_count count of channel ch_sel (combinational), 0 if ch_sel is out of range
//
// master: the CPU / bench side.  slave: the timer.
interface multi_counter_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [CH_W-1:0]   ch_sel;
  logic              set;
  logic              stop;
  logic              mode;
  logic [WIDTH-1:0]  val1;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] pending;
  logic              c_int;
  logic [WIDTH-1:0]  rd_count;

  modport master (
    output ch_sel, set, stop, mode, val1, ack,
    input  pending, c_int, rd_count
  );

  modport slave (
    input  ch_sel, set, stop, mode, val1, ack,
    output pending, c_int, rd_count
  );
endinterface

// File: rtl/multi_counter.sv
// multi_counter -- NUM_CH independent WIDTH-bit interval timers sharing one
// prescaler. Each channel counts 0..cmp on every prescaler tick, flags a
// sticky pending bit on reaching cmp, then either wraps (periodic) or
// disables itself (one-shot). c_int is the OR of all pending bits.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous active-low reset, clears all state immediately
//   bus    multi_counter_if.slave (ch_sel/set/stop/mode/val1/ack in,
//          pending/c_int/rd_count out)
module multi_counter #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic           clk,
  input logic           reset,
  multi_counter_if.slave bus
);

  // ---------------------------------------------------------------------
  // Shared prescaler: free-running 0..PRESCALE-1, tick on the last value.
  // set never restarts it, so latency from set depends on its phase.
  // ---------------------------------------------------------------------
  logic tick;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int               PRE_W    = $clog2(PRESCALE);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
      logic [PRE_W-1:0] pre;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pre <= '0;
        end else if (pre == PRE_LAST) begin
          pre <= '0;
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end

      assign tick = (pre == PRE_LAST);
    end else begin : g_nopre
      assign tick = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  cnt [NUM_CH];
  logic [WIDTH-1:0]  cmp [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] per;
  logic [NUM_CH-1:0] pend;

  logic [NUM_CH-1:0] set_hit;
  logic [NUM_CH-1:0] stop_hit;
  logic [NUM_CH-1:0] match;

  // Decode of the addressed commands. An out-of-range ch_sel matches no
  // channel, so set/stop are dropped there. A match is suppressed whenever
  // set or stop addresses the channel in the same cycle: those commands
  // take priority and must not leave a stale pending behind.
  always_comb begin
    set_hit  = '0;
    stop_hit = '0;
    match    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      set_hit[i]  = bus.set && (bus.ch_sel == CH_W'(i));
      stop_hit[i] = bus.stop && (bus.ch_sel == CH_W'(i)) && !set_hit[i];
      match[i]    = en[i] && tick && (cnt[i] == cmp[i]) &&
                    !set_hit[i] && !stop_hit[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        cmp[i] <= '1;
      end
      en   <= '0;
      per  <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (set_hit[i]) begin
          cnt[i] <= '0;
          cmp[i] <= bus.val1;
          per[i] <= bus.mode;
          en[i]  <= 1'b1;
        end else if (stop_hit[i]) begin
          en[i] <= 1'b0;
        end else if (match[i]) begin
          cnt[i] <= '0;
          if (!per[i]) begin
            en[i] <= 1'b0;
          end
        end else if (en[i] && tick) begin
          // Wraps modulo 2^WIDTH; only reachable if cnt ever passed cmp.
          cnt[i] <= cnt[i] + WIDTH'(1);
        end

        // Match beats ack so an interrupt raised in the ack cycle is not lost.
        if (match[i]) begin
          pend[i] <= 1'b1;
        end else if (bus.ack[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_sel == CH_W'(i)) begin
        rd_mux = cnt[i];
      end
    end
  end

  assign bus.rd_count = rd_mux;
  assign bus.pending  = pend;
  assign bus.c_int    = |pend;

endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter -- self-checking bench for multi_counter.
// dut  : NUM_CH=4, WIDTH=32, PRESCALE=1, checked every cycle against an
//        arithmetic model that derives each channel's count and matches from
//        the edge at which it was set (count = ticks since set mod (cmp+1)).
// dut4 : same with PRESCALE=4, used for prescaler latency and async reset.
module tb_multi_counter;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int VW     = NUM_CH + 1 + WIDTH;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset4 = 1'b1;

  int tests_run = 0;
  int fails     = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  multi_counter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();
  multi_counter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus4 ();

  multi_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multi_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE(4)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  // ---------------- reference model ----------------
  longint edge_n;
  bit     started [NUM_CH];
  bit     stopped [NUM_CH];
  bit     per_m   [NUM_CH];
  bit     pend_m  [NUM_CH];
  longint set_edge[NUM_CH];
  longint cmp_m   [NUM_CH];
  longint frozen  [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      started[c]  = 1'b0;
      stopped[c]  = 1'b0;
      per_m[c]    = 1'b0;
      pend_m[c]   = 1'b0;
      set_edge[c] = 0;
      cmp_m[c]    = 0;
      frozen[c]   = 0;
    end
  endtask

  // Count of channel c as seen after edge e.
  function automatic longint cnt_at(int c, longint e);
    longint n;
    if (!started[c]) return 0;
    if (stopped[c]) return frozen[c];
    n = e - set_edge[c];
    if (per_m[c]) return n % (cmp_m[c] + 1);
    return (n <= cmp_m[c]) ? n : 0;
  endfunction

  // Apply the inputs present at edge edge_n to the model.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit     sh;
      bit     st;
      bit     run;
      bit     m;
      longint n;
      sh  = bus.set && (int'(bus.ch_sel) == c);
      st  = bus.stop && (int'(bus.ch_sel) == c) && !sh;
      n   = edge_n - set_edge[c];
      run = started[c] && !stopped[c] && (per_m[c] || n <= cmp_m[c] + 1);
      m   = !sh && !st && run && (n > 0) && ((n % (cmp_m[c] + 1)) == 0);
      if (m) pend_m[c] = 1'b1;
      else if (bus.ack[c]) pend_m[c] = 1'b0;
      if (sh) begin
        started[c]  = 1'b1;
        stopped[c]  = 1'b0;
        set_edge[c] = edge_n;
        cmp_m[c]    = longint'(bus.val1);
        per_m[c]    = bus.mode;
      end else if (st && started[c]) begin
        frozen[c]  = cnt_at(c, edge_n - 1);
        stopped[c] = 1'b1;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NUM_CH-1:0] p;
    logic [WIDTH-1:0]  rd;
    p = '0;
    for (int c = 0; c < NUM_CH; c++) p[c] = pend_m[c];
    rd = WIDTH'(cnt_at(int'(bus.ch_sel), edge_n));
    return {p, |p, rd};
  endfunction

  // ---------------- driver ----------------
  // One clock edge on dut; set/stop are single-cycle pulses.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    bus.set  = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic drive_set(int ch, int v, bit m, bit with_stop);
    bus.ch_sel = 2'(ch);
    bus.val1   = WIDTH'(v);
    bus.mode   = m;
    bus.set    = 1'b1;
    bus.stop   = with_stop;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    reset  = 1'b0;
    reset4 = 1'b0;
    #1;
    tests_run++;
    if ({bus.pending, bus.c_int, bus.rd_count} !== '0) begin
      fails++;
      $display("FAIL reset_async got %h exp 0", {bus.pending, bus.c_int, bus.rd_count});
    end
    tests_run++;
    if ({bus4.pending, bus4.c_int, bus4.rd_count} !== '0) begin
      fails++;
      $display("FAIL reset_async4 got %h exp 0", {bus4.pending, bus4.c_int, bus4.rd_count});
    end
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    edge_n = 0;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      bus.ch_sel = 2'(i % 4);
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== '0) begin
        fails++;
        $display("FAIL reset_idle edge %0d got %h exp 0", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count});
      end
    end
  endtask

  task automatic test_periodic();
    longint k;
    bit     e;
    drive_set(0, 5, 1'b1, 1'b0);
    step();
    k = edge_n;
    for (int i = 1; i <= 20; i++) begin
      bus.ack = (i == 7) ? 4'b0001 : 4'b0000;
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== exp_vec()) begin
        fails++;
        $display("FAIL periodic_model edge %0d got %h exp %h", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count}, exp_vec());
      end
      if (i == 5 || i == 6 || i == 7 || i == 11 || i == 12 || i == 18) begin
        e = (i == 6 || i == 12 || i == 18);
        tests_run++;
        if (bus.pending[0] !== e || bus.c_int !== e) begin
          fails++;
          $display("FAIL periodic_pend edge k+%0d got pend0=%b c_int=%b exp %b",
                   edge_n - k, bus.pending[0], bus.c_int, e);
        end
      end
    end
    bus.ack = '0;
    bus.stop = 1'b1;
    step();
    bus.ack = 4'b1111;
    step();
    bus.ack = '0;
  endtask

  task automatic test_oneshot();
    drive_set(2, 3, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 26; i++) begin
      bus.ack = (i == 6) ? 4'b0100 : 4'b0000;
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== exp_vec()) begin
        fails++;
        $display("FAIL oneshot_model edge %0d got %h exp %h", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count}, exp_vec());
      end
      if (i == 3 || i == 4) begin
        tests_run++;
        if (bus.pending[2] !== (i == 4)) begin
          fails++;
          $display("FAIL oneshot_pend i=%0d got %b exp %b", i, bus.pending[2], (i == 4));
        end
      end
      if (i >= 6) begin
        tests_run++;
        if (bus.pending[2] !== 1'b0 || bus.rd_count !== '0) begin
          fails++;
          $display("FAIL oneshot_done i=%0d got pend2=%b rd=%0d exp 0/0", i,
                   bus.pending[2], bus.rd_count);
        end
      end
    end
    bus.ack = '0;
  endtask

  task automatic test_ack_held();
    bus.ack = 4'b0010;
    drive_set(1, 2, 1'b1, 1'b0);
    step();
    for (int i = 1; i <= 15; i++) begin
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== exp_vec()) begin
        fails++;
        $display("FAIL ackheld_model edge %0d got %h exp %h", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count}, exp_vec());
      end
      tests_run++;
      if (bus.pending[1] !== ((i % 3) == 0)) begin
        fails++;
        $display("FAIL ackheld_pend i=%0d got %b exp %b", i, bus.pending[1], ((i % 3) == 0));
      end
    end
    bus.stop = 1'b1;
    step();
    bus.ack = '0;
  endtask

  task automatic test_stop_set();
    drive_set(3, 10, 1'b1, 1'b0);
    step();
    repeat (4) step();
    bus.stop = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (bus.rd_count !== 32'd4 || bus.pending[3] !== 1'b0) begin
        fails++;
        $display("FAIL stop_frozen i=%0d got rd=%0d pend3=%b exp 4/0", i,
                 bus.rd_count, bus.pending[3]);
      end
    end
    drive_set(3, 1, 1'b1, 1'b1);
    step();
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== exp_vec()) begin
        fails++;
        $display("FAIL setstop_model edge %0d got %h exp %h", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count}, exp_vec());
      end
      if (i <= 2) begin
        tests_run++;
        if (bus.pending[3] !== (i == 2)) begin
          fails++;
          $display("FAIL setstop_pend i=%0d got %b exp %b", i, bus.pending[3], (i == 2));
        end
      end
    end
    bus.stop = 1'b1;
    bus.ack  = 4'b1111;
    step();
    bus.ack  = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.ch_sel = 2'($urandom_range(0, 3));
      bus.set    = ($urandom_range(0, 9) == 0);
      bus.stop   = ($urandom_range(0, 14) == 0);
      bus.mode   = 1'($urandom_range(0, 1));
      bus.val1   = WIDTH'($urandom_range(0, 6));
      bus.ack    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
      tests_run++;
      if ({bus.pending, bus.c_int, bus.rd_count} !== exp_vec()) begin
        fails++;
        $display("FAIL random edge %0d got %h exp %h", edge_n,
                 {bus.pending, bus.c_int, bus.rd_count}, exp_vec());
      end
    end
    bus.ack = '0;
  endtask

  task automatic test_prescale();
    int e4;
    int s;
    int exp_lat;
    int lat;
    @(posedge clk);
    #1;
    reset4 = 1'b1;
    e4 = 0;
    repeat ($urandom_range(0, 7)) begin
      @(posedge clk);
      e4++;
      #1;
    end
    bus4.ch_sel = '0;
    bus4.val1   = 32'd2;
    bus4.mode   = 1'b1;
    bus4.set    = 1'b1;
    @(posedge clk);
    e4++;
    s = e4;
    #1;
    bus4.set = 1'b0;
    // Ticks fall on edges 4,8,... after release; match on the third tick after set.
    exp_lat = ((s / 4) + 1) * 4 + 8 - s;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      e4++;
      #1;
      if (bus4.pending[0] && lat == 0) lat = i;
    end
    tests_run++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL prescale_latency got %0d exp %0d", lat, exp_lat);
    end
    tests_run++;
    if (lat < 9 || lat > 12) begin
      fails++;
      $display("FAIL prescale_range got %0d exp 9..12", lat);
    end
    #2;
    reset4 = 1'b0;
    #1;
    tests_run++;
    if ({bus4.pending, bus4.c_int, bus4.rd_count} !== '0) begin
      fails++;
      $display("FAIL prescale_async_reset got %h exp 0", {bus4.pending, bus4.c_int, bus4.rd_count});
    end
    @(posedge clk);
    #1;
    reset4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus4.pending, bus4.c_int, bus4.rd_count} !== '0) begin
        fails++;
        $display("FAIL prescale_after_reset i=%0d got %h exp 0", i,
                 {bus4.pending, bus4.c_int, bus4.rd_count});
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.ch_sel  = '0;
    bus.set     = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = 1'b0;
    bus.val1    = '0;
    bus.ack     = '0;
    bus4.ch_sel = '0;
    bus4.set    = 1'b0;
    bus4.stop   = 1'b0;
    bus4.mode   = 1'b0;
    bus4.val1   = '0;
    bus4.ack    = '0;
    edge_n      = 0;
    model_reset();

    test_reset();
    test_periodic();
    test_oneshot();
    test_ack_held();
    test_stop_set();
    test_random();
    test_prescale();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
